// File: rtl/n1_accum_tree.sv
// NFU-2 reduction stage: TN independent TI-input adder trees feeding per-lane group accumulators.
// Optional build macro N1_SATURATE_EN clamps o_res to the signed N-bit range instead of wrapping.

module n1_accum_tree_chk #(
   parameter int N     = 16,
   parameter int TN    = 16,
   parameter int CNT_W = 8
) (
   input logic             clk,
   input logic             rst,
   input logic             i_stall,
   input logic             o_valid,
   input logic [TN*N-1:0]  o_res,
   input logic [CNT_W-1:0] o_beats
);

   // A stalled cycle must leave every output register untouched.
   a_stall_hold: assert property (@(posedge clk) disable iff (rst)
      i_stall |=> ($stable(o_valid) && $stable(o_res) && $stable(o_beats)));

   // A completed group always contains at least one beat.
   a_beats_nonzero: assert property (@(posedge clk) disable iff (rst)
      o_valid |-> (o_beats != {CNT_W{1'b0}}));

endmodule

module n1_accum_tree #(
   parameter int N          = 16,
   parameter int TI         = 16,
   parameter int TN         = 16,
   parameter int REG_STRIDE = 2,
   parameter int CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_stall,
   input  logic                 i_valid,
   input  logic                 i_first,
   input  logic                 i_last,
   input  logic [TN*TI*N-1:0]   i_vals,
   output logic                 o_valid,
   output logic [TN*N-1:0]      o_res,
   output logic [CNT_W-1:0]     o_beats
);

   localparam int LV = $clog2(TI);
   localparam int D  = LV / REG_STRIDE;
   localparam int SW = N + LV;
   localparam int AW = SW + CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef N1_SATURATE_EN
   function automatic logic [N-1:0] clamp_res(input logic [AW-1:0] a);
      logic signed [AW-1:0] s_v;
      logic signed [AW-1:0] hi_v;
      logic signed [AW-1:0] lo_v;
      s_v  = a;
      hi_v = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
      lo_v = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
      if (s_v > hi_v) begin
         clamp_res = {1'b0, {(N-1){1'b1}}};
      end else if (s_v < lo_v) begin
         clamp_res = {1'b1, {(N-1){1'b0}}};
      end else begin
         clamp_res = a[N-1:0];
      end
   endfunction
`endif

   // Tree nodes are carried at the final width SW; sign extension keeps every partial sum exact.
   logic [SW-1:0]    stg_r     [1:D][0:TN-1][0:TI-1];
   logic [SW-1:0]    stg_nxt_s [1:D][0:TN-1][0:TI-1];
   logic [SW-1:0]    tree_s    [0:TN-1];
   logic [D-1:0]     vld_r;
   logic [D-1:0]     fst_r;
   logic [D-1:0]     lst_r;
   logic [AW-1:0]    acc_r     [0:TN-1];
   logic [AW-1:0]    acc_nxt_s [0:TN-1];
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [TN*N-1:0]  res_nxt_s;
   logic             beat_s;
   logic             close_s;

   // Adder tree: stage s folds its levels in place, then hands the survivors to register stage s+1.
   always_comb begin
      logic [SW-1:0] v_v [0:TI-1];
      int            lv_hi;
      for (int s = 1; s <= D; s++) begin
         for (int t = 0; t < TN; t++) begin
            for (int i = 0; i < TI; i++) begin
               stg_nxt_s[s][t][i] = {SW{1'b0}};
            end
         end
      end
      for (int t = 0; t < TN; t++) begin
         tree_s[t] = {SW{1'b0}};
      end
      for (int t = 0; t < TN; t++) begin
         for (int i = 0; i < TI; i++) begin
            v_v[i] = {{LV{i_vals[(t*TI+i)*N + N - 1]}}, i_vals[(t*TI+i)*N +: N]};
         end
         for (int s = 0; s <= D; s++) begin
            lv_hi = (s == D) ? LV : (s + 1) * REG_STRIDE;
            for (int k = s * REG_STRIDE + 1; k <= lv_hi; k++) begin
               for (int i = 0; i < TI / 2; i++) begin
                  v_v[i] = v_v[2*i] + v_v[2*i+1];
               end
               for (int i = TI / 2; i < TI; i++) begin
                  v_v[i] = {SW{1'b0}};
               end
            end
            if (s < D) begin
               for (int i = 0; i < TI; i++) begin
                  stg_nxt_s[s+1][t][i] = v_v[i];
                  v_v[i]               = stg_r[s+1][t][i];
               end
            end else begin
               tree_s[t] = v_v[0];
            end
         end
      end
   end

   // Tree pipeline registers and the matching valid/first/last tag shift chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 1; s <= D; s++) begin
            for (int t = 0; t < TN; t++) begin
               for (int i = 0; i < TI; i++) begin
                  stg_r[s][t][i] <= {SW{1'b0}};
               end
            end
         end
         vld_r <= {D{1'b0}};
         fst_r <= {D{1'b0}};
         lst_r <= {D{1'b0}};
      end else if (!i_stall) begin
         stg_r    <= stg_nxt_s;
         vld_r[0] <= i_valid;
         fst_r[0] <= i_first;
         lst_r[0] <= i_last;
         for (int s = 1; s < D; s++) begin
            vld_r[s] <= vld_r[s-1];
            fst_r[s] <= fst_r[s-1];
            lst_r[s] <= lst_r[s-1];
         end
      end
   end

   // Accumulate/restart per lane and advance the saturating beat counter.
   always_comb begin
      beat_s    = vld_r[D-1];
      close_s   = vld_r[D-1] & lst_r[D-1];
      cnt_nxt_s = cnt_r;
      res_nxt_s = {(TN*N){1'b0}};
      for (int t = 0; t < TN; t++) begin
         acc_nxt_s[t] = acc_r[t];
         if (!beat_s) begin
            acc_nxt_s[t] = acc_r[t];
         end else if (fst_r[D-1]) begin
            acc_nxt_s[t] = {{CNT_W{tree_s[t][SW-1]}}, tree_s[t]};
         end else begin
            acc_nxt_s[t] = acc_r[t] + {{CNT_W{tree_s[t][SW-1]}}, tree_s[t]};
         end
`ifdef N1_SATURATE_EN
         res_nxt_s[t*N +: N] = clamp_res(acc_nxt_s[t]);
`else
         res_nxt_s[t*N +: N] = acc_nxt_s[t][N-1:0];
`endif
      end
      if (!beat_s) begin
         cnt_nxt_s = cnt_r;
      end else if (fst_r[D-1]) begin
         cnt_nxt_s = CNT_ONE;
      end else if (cnt_r == CNT_MAX) begin
         cnt_nxt_s = cnt_r;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // Accumulator state and registered group outputs; results hold until the next closing beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < TN; t++) begin
            acc_r[t] <= {AW{1'b0}};
         end
         cnt_r   <= {CNT_W{1'b0}};
         o_valid <= 1'b0;
         o_res   <= {(TN*N){1'b0}};
         o_beats <= {CNT_W{1'b0}};
      end else if (!i_stall) begin
         acc_r   <= acc_nxt_s;
         cnt_r   <= cnt_nxt_s;
         o_valid <= close_s;
         if (close_s) begin
            o_res   <= res_nxt_s;
            o_beats <= cnt_nxt_s;
         end
      end
   end

   n1_accum_tree_chk #(
      .N     (N),
      .TN    (TN),
      .CNT_W (CNT_W)
   ) u_chk (
      .clk     (clk),
      .rst     (rst),
      .i_stall (i_stall),
      .o_valid (o_valid),
      .o_res   (o_res),
      .o_beats (o_beats)
   );

endmodule

// File: tb/tb_n1_accum_tree.sv
// Testbench for n1_accum_tree: directed vector table, hand-written corner sequences, random vs reference model.
module tb_n1_accum_tree;

   localparam int N     = 16;
   localparam int TI    = 16;
   localparam int TN    = 16;
   localparam int RS    = 2;
   localparam int CNT_W = 8;
   localparam int LV    = 4;
   localparam int AW    = N + LV + CNT_W;

   logic                clk = 1'b0;
   logic                rst;
   logic                i_stall;
   logic                i_valid;
   logic                i_first;
   logic                i_last;
   logic [TN*TI*N-1:0]  i_vals;
   logic                o_valid;
   logic [TN*N-1:0]     o_res;
   logic [CNT_W-1:0]    o_beats;

   int n_chk  = 0;
   int n_fail = 0;

   n1_accum_tree #(.N(N), .TI(TI), .TN(TN), .REG_STRIDE(RS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .i_stall(i_stall), .i_valid(i_valid), .i_first(i_first),
      .i_last(i_last), .i_vals(i_vals), .o_valid(o_valid), .o_res(o_res), .o_beats(o_beats)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st, v, f, l;
      int          mode;
      logic [15:0] val;
      logic        ev;
      logic [15:0] e0, el;
      logic [7:0]  eb;
   } row_t;

   typedef struct {
      logic            v;
      logic [TN*N-1:0] res;
      logic [7:0]      b;
   } item_t;

   row_t  tbl[$];
   item_t mq[$];
   logic [AW-1:0] acc_m [TN];
   int            cnt_m;

   task automatic check(input string name, input logic [TN*N-1:0] act, input logic [TN*N-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_all(input logic [N-1:0] v);
      for (int k = 0; k < TN*TI; k++) i_vals[k*N +: N] = v;
   endtask

   task automatic fill_lanes();
      for (int t = 0; t < TN; t++)
         for (int j = 0; j < TI; j++) i_vals[(t*TI+j)*N +: N] = N'(t + 1);
   endtask

   task automatic drive(input logic st, input logic v, input logic f, input logic l);
      i_stall = st; i_valid = v; i_first = f; i_last = l;
      @(posedge clk);
      #1;
   endtask

   function automatic row_t mk(input logic st, v, f, l, input int mode, input logic [15:0] val,
                               input logic ev, input logic [15:0] e0, el, input logic [7:0] eb);
      row_t r;
      r.st = st; r.v = v; r.f = f; r.l = l; r.mode = mode; r.val = val;
      r.ev = ev; r.e0 = e0; r.el = el; r.eb = eb;
      return r;
   endfunction

   function automatic longint lane_sum(input int t);
      longint s;
      logic signed [N-1:0] x;
      s = 0;
      for (int j = 0; j < TI; j++) begin
         x = i_vals[(t*TI+j)*N +: N];
         s += x;
      end
      return s;
   endfunction

   function automatic logic [N-1:0] ref_res(input logic [AW-1:0] a);
      logic signed [AW-1:0] sa;
      longint sv;
      sa = a;
      sv = sa;
`ifdef N1_SATURATE_EN
      if (sv > 32767) return 16'h7FFF;
      if (sv < -32768) return 16'h8000;
`endif
      return a[N-1:0];
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      item_t it;
      logic            exp_v;
      logic [TN*N-1:0] exp_res;
      logic [7:0]      exp_b;
      logic [15:0]     ovf;
      longint          s;

      rst = 1'b1; i_stall = 1'b0; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
      i_vals = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("reset o_valid", o_valid, 0);
      check("reset o_res", o_res, 0);
      check("reset o_beats", o_beats, 0);
      rst = 1'b0;

      //            st v  f  l  mode val       ev  lane0     laneL     beats
      tbl.push_back(mk(0, 1, 1, 1, 1, 16'd1,     0, 16'd0,    16'd0,    8'd0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd0,    16'd0,    8'd0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     1, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 1, 1, 0, 2, 16'd0,     0, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 1, 0, 0, 2, 16'd0,     0, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 1, 0, 0, 2, 16'd0,     0, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 1, 0, 1, 2, 16'd0,     0, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     1, 16'd64,   16'd1024, 8'd4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd64,   16'd1024, 8'd4));
      tbl.push_back(mk(0, 1, 1, 1, 1, 16'd2,     0, 16'd64,   16'd1024, 8'd4));
      tbl.push_back(mk(0, 1, 1, 1, 1, 16'hFFFF,  0, 16'd64,   16'd1024, 8'd4));
      tbl.push_back(mk(0, 1, 1, 1, 1, 16'd2,     1, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     1, 16'hFFF0, 16'hFFF0, 8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     1, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 1, 1, 0, 2, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 2, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 1, 0, 0, 2, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1, 1, 0, 0, 2, 16'd0,  0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 1, 0, 0, 2, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 2, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 1, 0, 1, 2, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'd0,     0, 16'd32,   16'd32,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     1, 16'd64,   16'd1024, 8'd4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd64,   16'd1024, 8'd4));
      tbl.push_back(mk(0, 1, 1, 1, 1, 16'd3,     0, 16'd64,   16'd1024, 8'd4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd64,   16'd1024, 8'd4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     1, 16'd48,   16'd48,   8'd1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'd0,     1, 16'd48,   16'd48,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd48,   16'd48,   8'd1));
      tbl.push_back(mk(0, 1, 1, 0, 1, 16'd5,     0, 16'd48,   16'd48,   8'd1));
      tbl.push_back(mk(0, 1, 1, 1, 1, 16'd1,     0, 16'd48,   16'd48,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd48,   16'd48,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     1, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 1, 0, 1, 1, 16'd1,     0, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd16,   16'd16,   8'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     1, 16'd32,   16'd32,   8'd2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'd0,     0, 16'd32,   16'd32,   8'd2));

      for (int k = 0; k < tbl.size(); k++) begin
         case (tbl[k].mode)
            1:       fill_all(tbl[k].val);
            2:       fill_lanes();
            default: fill_all(16'h0000);
         endcase
         drive(tbl[k].st, tbl[k].v, tbl[k].f, tbl[k].l);
         check($sformatf("tbl[%0d] o_valid", k), o_valid, tbl[k].ev);
         check($sformatf("tbl[%0d] lane0", k), o_res[N-1:0], tbl[k].e0);
         check($sformatf("tbl[%0d] lane15", k), o_res[(TN-1)*N +: N], tbl[k].el);
         check($sformatf("tbl[%0d] o_beats", k), o_beats, tbl[k].eb);
      end

      // Overflow: two beats of all 0x7FFF, full sum 1048544.
`ifdef N1_SATURATE_EN
      ovf = 16'h7FFF;
`else
      ovf = 16'hFFE0;
`endif
      fill_all(16'h7FFF);
      drive(0, 1, 1, 0);
      drive(0, 1, 0, 1);
      drive(0, 0, 0, 0);
      check("ovf early o_valid", o_valid, 0);
      drive(0, 0, 0, 0);
      check("ovf o_valid", o_valid, 1);
      check("ovf lane0", o_res[N-1:0], ovf);
      check("ovf lane15", o_res[(TN-1)*N +: N], ovf);
      check("ovf o_beats", o_beats, 2);

      // Beat counter saturation over a 300-beat group.
      fill_all(16'h0000);
      for (int b = 0; b < 300; b++) drive(0, 1, b == 0, b == 299);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      check("sat o_valid", o_valid, 1);
      check("sat o_beats", o_beats, 255);
      check("sat lane0", o_res[N-1:0], 0);

      // Asynchronous reset mid-group, then a first=0 single beat.
      fill_all(16'h0001);
      drive(0, 1, 1, 0);
      drive(0, 1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check("async rst o_valid", o_valid, 0);
      check("async rst o_res", o_res, 0);
      check("async rst o_beats", o_beats, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 1, 0, 1);
      drive(0, 0, 0, 0);
      check("post rst early o_valid", o_valid, 0);
      drive(0, 0, 0, 0);
      check("post rst o_valid", o_valid, 1);
      check("post rst lane0", o_res[N-1:0], 16);
      check("post rst lane15", o_res[(TN-1)*N +: N], 16);
      check("post rst o_beats", o_beats, 1);

      // Randomised run against the reference model.
      rst = 1'b1; i_stall = 1'b0; i_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int t = 0; t < TN; t++) acc_m[t] = '0;
      cnt_m = 0;
      mq.delete();
      it.v = 1'b0; it.res = '0; it.b = '0;
      mq.push_back(it);
      mq.push_back(it);
      exp_v = 1'b0; exp_res = '0; exp_b = '0;
      for (int c = 0; c < 1500; c++) begin
         i_stall = ($urandom_range(0, 9) == 0);
         i_valid = ($urandom_range(0, 9) < 7);
         i_first = ($urandom_range(0, 4) == 0);
         i_last  = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < TN*TI*N/32; k++) i_vals[k*32 +: 32] = $urandom();
         if ($urandom_range(0, 15) == 0) fill_all(16'h7FFF);
         if (!i_stall) begin
            it.v = 1'b0; it.res = '0; it.b = '0;
            if (i_valid) begin
               for (int t = 0; t < TN; t++) begin
                  s = lane_sum(t);
                  acc_m[t] = i_first ? AW'(s) : acc_m[t] + AW'(s);
               end
               cnt_m = i_first ? 1 : ((cnt_m < 255) ? cnt_m + 1 : 255);
               if (i_last) begin
                  it.v = 1'b1;
                  for (int t = 0; t < TN; t++) it.res[t*N +: N] = ref_res(acc_m[t]);
                  it.b = 8'(cnt_m);
               end
            end
            mq.push_back(it);
            it = mq.pop_front();
            exp_v = it.v;
            if (it.v) begin
               exp_res = it.res;
               exp_b   = it.b;
            end
         end
         @(posedge clk); #1;
         check($sformatf("rnd[%0d] o_valid", c), o_valid, exp_v);
         check($sformatf("rnd[%0d] o_res", c), o_res, exp_res);
         check($sformatf("rnd[%0d] o_beats", c), o_beats, exp_b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/n1_accum_tree.md
Name: n1_accum_tree

Overview:
- Second-generation NFU-2 reduction stage. TN independent TI-input adder trees feed per-lane accumulators.
- Sums partial products across multiple passes (input-neuron blocks) and emits one result per lane per completed group.
- Generalises the fixed 16x16, single-register tree:
  - parametrised width, fan-in and lane count;
  - configurable pipeline register placement;
  - valid/first/last framing, global stall and a beat counter.
- Inputs arrive pre-grouped per lane, so there is no swizzle stage.

Parameters:
- N, 16, data width of inputs and o_res lanes (two's complement).
- TI, 16, inputs per tree; power of two, 2..64.
- TN, 16, number of lanes/trees.
- REG_STRIDE, 2, pipeline register inserted after every REG_STRIDE adder levels; 1..log2(TI).
- CNT_W, 8, width of beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_stall  in  1  global freeze of all state.
- i_valid  in  1  beat present on i_vals.
- i_first  in  1  beat opens a new accumulation group.
- i_last  in  1  beat closes the group.
- i_vals  in  TN*TI*N  lane t input j at bits [(t*TI+j)*N +: N].
- o_valid  out  1  one-cycle pulse: o_res holds a completed group.
- o_res  out  TN*N  lane t result at bits [t*N +: N].
- o_beats  out  CNT_W  number of beats in the completed group, valid with o_valid.

Behaviour:
- Reset (async, any cycle, including mid-group):
  - all pipeline valid bits, first/last tags, accumulators and the beat counter clear to 0;
  - o_valid=0, o_res=0, o_beats=0.
- Tree adders:
  - LV = log2(TI) levels of pairwise adds, ordering [2k]+[2k+1];
  - full precision, each level one bit wider, final tree sum N+LV bits;
  - register after level k (k=1..LV) when k % REG_STRIDE == 0;
  - D = floor(LV/REG_STRIDE) tree stages. Defaults: D=2.
- Tags: i_valid, i_first and i_last travel in a shift pipeline alongside the data, D stages deep.
- Accumulator stage (one register): on a valid beat leaving the tree,
  - acc = first ? tree_sum : acc + tree_sum;
  - AW = N+LV+CNT_W bits, wraps modulo 2^AW.
- Beat counter: set to 1 on a first beat, otherwise incremented; saturates at 2^CNT_W-1.
- Latency:
  - o_valid asserts D+1 unstalled cycles after the accepted last beat (defaults: 3);
  - o_res = low N bits of the updated acc (wrap);
  - o_beats = updated count.
- o_res and o_beats hold their values until the next o_valid. o_valid is 0 in all other cycles.
- first&last on the same beat: single-pass group, o_beats=1.
- Valid beat without first while no group is open: accumulates onto the current acc, which is 0 after reset.
- A first beat arriving mid-group silently restarts the group and discards the old sum.
- i_valid=0 bubbles: no acc or counter change; gaps between beats of a group are allowed.
- i_stall=1:
  - every register holds, including o_valid, o_res and o_beats;
  - i_valid is ignored that cycle;
  - a downstream transfer is o_valid & ~i_stall.
- Throughput: one beat per cycle when unstalled.

Optional Feature:
- Macro N1_SATURATE_EN.
- Defined: o_res = acc clamped to [-2^(N-1), 2^(N-1)-1]; acc itself still wraps at AW bits.
- Undefined: o_res = acc[N-1:0] (wrap-around), matching first-generation behaviour.

Test Plan:
- Single pass, defaults: one beat with first=last=1, all 256 inputs = 1 -> 3 cycles later o_valid=1, every lane o_res=16, o_beats=1.
- Four-beat group, lane t inputs all = t+1, contiguous -> one o_valid pulse 3 cycles after beat 4, lane t o_res=64*(t+1), o_beats=4.
- Stall and bubbles: same group with i_valid gaps and i_stall=1 held 5 cycles mid-flight -> identical results; o_valid appears exactly 5 cycles later; no duplicate pulse.
- Back-to-back groups: first/last on every beat, lane 0 inputs alternating all 2 / all -1 -> o_valid every cycle, o_res alternating 32 / -16.
- Overflow, all inputs 0x7FFF, 2 beats:
  - without macro: lane o_res = 0xFFE0, the wrapped low 16 bits of 1048544;
  - with N1_SATURATE_EN: o_res = 0x7FFF.
- Async reset asserted mid-group after 2 beats, then a fresh single beat of all 1 with first=0 -> o_res=16, o_beats=1, no stale sum.
